pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_if.sv | 48 ++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Holds the memory FSM state encoding and the register-match helper.
package pipe_ctrl_pkg;

  localparam int MEM_TIMEOUT_DEF = 15;
  localparam int CNT_W_DEF       = 16;
  localparam int REG_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } mem_state_t;

  // True when destination d is a source that ID actually reads.
  function automatic logic reg_match(
    input logic [REG_W-1:0] d,
    input logic [REG_W-1:0] src1,
    input logic             src1_used,
    input logic [REG_W-1:0] src2,
    input logic             two_src
  );
    return (src1_used && (d == src1)) || (two_src && (d == src2));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle for pipe_hazard_ctrl.
// The slave modport is the controller's view; master is the pipeline's view.
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             forward_en;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_src1_used;
  logic             id_two_src;
  logic [REG_W-1:0] exe_dest;
  logic [REG_W-1:0] mem_dest;
  logic             exe_wb_en;
  logic             mem_wb_en;
  logic             exe_mem_read;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             clr_stats;

  logic             freeze_front;
  logic             stall_all;
  logic             flush_if_id;
  logic             flush_id_exe;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output forward_en, id_src1, id_src2, id_src1_used, id_two_src,
           exe_dest, mem_dest, exe_wb_en, mem_wb_en, exe_mem_read,
           branch_taken, mem_req, mem_ready, clr_stats,
    input  freeze_front, stall_all, flush_if_id, flush_id_exe, mem_error,
           stall_cycles, flush_count
  );

  modport slave (
    input  forward_en, id_src1, id_src2, id_src1_used, id_two_src,
           exe_dest, mem_dest, exe_wb_en, mem_wb_en, exe_mem_read,
           branch_taken, mem_req, mem_ready, clr_stats,
    output freeze_front, stall_all, flush_if_id, flush_id_exe, mem_error,
           stall_cycles, flush_count
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear that beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count events, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: data-hazard detection, memory-wait
// stall FSM with timeout trap, flush/freeze priority and statistics counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  mem_state_t        r_state;
  logic [WCNT_W-1:0] r_wait_cnt;

  logic w_exe_match;
  logic w_mem_match;
  logic w_hazard;
  logic w_stall_all;
  logic w_flush_if_id;
  logic w_flush_id_exe;
  logic w_freeze_front;

  // Data hazard; with forwarding only a load in EXE cannot be bypassed.
  always_comb begin
    w_exe_match = reg_match(bus.exe_dest, bus.id_src1, bus.id_src1_used,
                            bus.id_src2, bus.id_two_src);
    w_mem_match = reg_match(bus.mem_dest, bus.id_src1, bus.id_src1_used,
                            bus.id_src2, bus.id_two_src);
    if (bus.forward_en) begin
      w_hazard = bus.exe_mem_read & bus.exe_wb_en & w_exe_match;
    end else begin
      w_hazard = (bus.exe_wb_en & w_exe_match) | (bus.mem_wb_en & w_mem_match);
    end
  end

  // Whole-pipe stall from the memory FSM; a zero-wait access never stalls.
  always_comb begin
    case (r_state)
      ST_IDLE:  w_stall_all = bus.mem_req & ~bus.mem_ready;
      ST_WAIT:  w_stall_all = ~bus.mem_ready;
      ST_ERROR: w_stall_all = 1'b1;
      default:  w_stall_all = 1'b1;
    endcase
  end

  // Priority: stall_all, then branch, then hazard.
  always_comb begin
    w_flush_if_id  = bus.branch_taken & ~w_stall_all;
    w_flush_id_exe = (bus.branch_taken | w_hazard) & ~w_stall_all;
    w_freeze_front = w_stall_all | (w_hazard & ~bus.branch_taken);
  end

  // Memory access FSM; ERROR is only left through rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.mem_req && !bus.mem_ready) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= WCNT_W'(1);
          end else begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (bus.mem_ready) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WCNT_W'(MEM_TIMEOUT - 1)) begin
            r_state    <= ST_ERROR;
            r_wait_cnt <= WCNT_W'(MEM_TIMEOUT);
          end else begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
          end
        end
        ST_ERROR: begin
          r_state    <= ST_ERROR;
          r_wait_cnt <= r_wait_cnt;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_freeze_front),
    .i_clr (bus.clr_stats),
    .o_cnt (bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_flush_if_id),
    .i_clr (bus.clr_stats),
    .o_cnt (bus.flush_count)
  );

  assign bus.freeze_front = w_freeze_front;
  assign bus.stall_all    = w_stall_all;
  assign bus.flush_if_id  = w_flush_if_id;
  assign bus.flush_id_exe = w_flush_id_exe;
  assign bus.mem_error    = (r_state == ST_ERROR);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push hand-written
// expectations, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) bus_if ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  typedef struct {
    string       name;
    logic        fr;
    logic        st;
    logic        fi;
    logic        fe;
    logic        me;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_sc  = 0;
  int   m_fc  = 0;

  task automatic cmp(input string nm, input string field,
                     input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s.%s got %0h expected %0h", nm, field, got, exp);
    end
  endtask

  // Monitor: every negedge with a pending expectation is one output sample.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.name, "freeze_front", 16'(bus_if.freeze_front), 16'(e.fr));
      cmp(e.name, "stall_all",    16'(bus_if.stall_all),    16'(e.st));
      cmp(e.name, "flush_if_id",  16'(bus_if.flush_if_id),  16'(e.fi));
      cmp(e.name, "flush_id_exe", 16'(bus_if.flush_id_exe), 16'(e.fe));
      cmp(e.name, "mem_error",    16'(bus_if.mem_error),    16'(e.me));
      cmp(e.name, "stall_cycles", bus_if.stall_cycles,      e.sc);
      cmp(e.name, "flush_count",  bus_if.flush_count,       e.fc);
    end
  end

  task automatic clr_in();
    bus_if.forward_en   = 1'b0;
    bus_if.id_src1      = 4'd0;
    bus_if.id_src2      = 4'd0;
    bus_if.id_src1_used = 1'b0;
    bus_if.id_two_src   = 1'b0;
    bus_if.exe_dest     = 4'd0;
    bus_if.mem_dest     = 4'd0;
    bus_if.exe_wb_en    = 1'b0;
    bus_if.mem_wb_en    = 1'b0;
    bus_if.exe_mem_read = 1'b0;
    bus_if.branch_taken = 1'b0;
    bus_if.mem_req      = 1'b0;
    bus_if.mem_ready    = 1'b0;
    bus_if.clr_stats    = 1'b0;
  endtask

  task automatic load_use();
    bus_if.forward_en   = 1'b1;
    bus_if.exe_mem_read = 1'b1;
    bus_if.exe_wb_en    = 1'b1;
    bus_if.exe_dest     = 4'd3;
    bus_if.id_src1      = 4'd3;
    bus_if.id_src1_used = 1'b1;
  endtask

  // Push this cycle's expectation, then advance the counter model over the edge.
  task automatic chk(input string nm, input logic fr, input logic st,
                     input logic fi, input logic fe, input logic me);
    exp_t e;
    e.name = nm; e.fr = fr; e.st = st; e.fi = fi; e.fe = fe; e.me = me;
    e.sc = 16'(m_sc); e.fc = 16'(m_fc);
    q.push_back(e);
    @(posedge clk);
    if (rst || bus_if.clr_stats) begin
      m_sc = 0;
      m_fc = 0;
    end else begin
      if (fr && m_sc < 65535) m_sc++;
      if (fi && m_fc < 65535) m_fc++;
    end
    #1;
  endtask

  initial begin
    clr_in();
    @(posedge clk); #1;
    chk("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    load_use();
    chk("load_use", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    clr_in();
    chk("after_lu", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    bus_if.mem_wb_en = 1'b1; bus_if.mem_dest = 4'd5;
    bus_if.id_two_src = 1'b1; bus_if.id_src2 = 4'd5;
    chk("nofwd_mem", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    bus_if.forward_en = 1'b1;
    chk("fwd_mem", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_in();
    bus_if.exe_wb_en = 1'b1; bus_if.exe_dest = 4'd7;
    bus_if.id_src1 = 4'd7; bus_if.id_src1_used = 1'b1;
    chk("nofwd_exe", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    bus_if.id_src1_used = 1'b0;
    chk("src_unused", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    clr_in(); load_use(); bus_if.branch_taken = 1'b1;
    chk("br_haz", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    clr_in();
    bus_if.branch_taken = 1'b1; bus_if.mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mwait%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    bus_if.mem_ready = 1'b1;
    chk("mwait_ready", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    clr_in();
    chk("mwait_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_if.mem_req = 1'b1; bus_if.mem_ready = 1'b1;
    chk("zero_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_in();
    chk("zero_wait_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    load_use(); bus_if.clr_stats = 1'b1;
    chk("clr_freeze", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    clr_in();
    chk("after_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    bus_if.mem_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      chk($sformatf("timeout%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, (i >= 16) ? 1'b1 : 1'b0);
    end
    clr_in();
    chk("err_sticky", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    bus_if.branch_taken = 1'b1;
    chk("err_no_flush", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    bus_if.branch_taken = 1'b0;
    #2;
    rst = 1'b1;
    m_sc = 0; m_fc = 0;
    chk("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    bus_if.mem_req = 1'b1;
    chk("post_rst_req", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_if.mem_ready = 1'b1;
    chk("post_rst_ready", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    clr_in(); load_use();
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      if (m_sc < 65535) m_sc++;
    end
    #1;
    chk("sat", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    bus_if.clr_stats = 1'b1;
    chk("sat_clr", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    clr_in();
    chk("sat_after_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    cmp("end", "queue_left", 16'(q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
